// File: rtl/fetch_pkg.sv
// Shared constants for the fetch sequencer: widths, opcode encodings and FSM states.
package fetch_pkg;

  localparam int PC_W    = 9;
  localparam int IW      = 16;
  localparam int DEPTH   = 8;
  localparam int DEPTH_W = $clog2(DEPTH);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH - 1);

  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ISSUE,
    ST_PUSH,
    ST_SETTLE,
    ST_HALTED,
    ST_ERR
  } state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the PC-bank, instruction-memory and decode handshakes of the fetch sequencer.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic [PC_W-1:0] pc_in;
  logic            pc_inc;
  logic            pc_ref_inc;
  logic            pc_ref_dec;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [IW-1:0]   imem_data;
  logic            instr_valid;
  logic [IW-1:0]   instr;
  logic            instr_ready;

  modport master (
    input  pc_in, imem_ack, imem_data, instr_ready,
    output pc_inc, pc_ref_inc, pc_ref_dec, imem_req, imem_addr, instr_valid, instr
  );

  modport slave (
    output pc_in, imem_ack, imem_data, instr_ready,
    input  pc_inc, pc_ref_inc, pc_ref_dec, imem_req, imem_addr, instr_valid, instr
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Fetches instruction words for decode and drives the PC bank's inc/push/pop strobes,
// tracking context depth locally so the bank never sees an out-of-range push or pop.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  fetch_sequencer_if.master  bus,
  output logic [DEPTH_W-1:0] depth,
  output logic               halted,
  output logic               err
);

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [IW-1:0]      instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               inc_q, inc_d;
  logic               ref_inc_q, ref_inc_d;
  logic               ref_dec_q, ref_dec_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               halted_q, halted_d;
  logic               err_q, err_d;

  logic [3:0] opcode;
  logic       strobe_busy;

  assign opcode      = instr_q[IW-1 -: 4];
  assign strobe_busy = inc_q | ref_inc_q | ref_dec_q;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    inc_d     = 1'b0;
    ref_inc_d = 1'b0;
    ref_dec_d = 1'b0;
    depth_d   = depth_q;
    halted_d  = halted_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = bus.pc_in;
        end
      end

      ST_REQ: begin
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          instr_d = bus.imem_data;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (valid_q && bus.instr_ready) begin
          valid_d = 1'b0;
          unique case (opcode)
            OP_CALL: begin
              inc_d   = 1'b1;
              state_d = ST_PUSH;
            end
            OP_RET: begin
              if (depth_q == '0) begin
                err_d   = 1'b1;
                state_d = ST_ERR;
              end else begin
                ref_dec_d = 1'b1;
                depth_d   = depth_q - DEPTH_W'(1);
                state_d   = ST_SETTLE;
              end
            end
            OP_HALT: begin
              halted_d = 1'b1;
              state_d  = ST_HALTED;
            end
            default: begin
              inc_d   = 1'b1;
              state_d = ST_SETTLE;
            end
          endcase
        end
      end

      ST_PUSH: begin
        if (depth_q == DEPTH_MAX) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          ref_inc_d = 1'b1;
          depth_d   = depth_q + DEPTH_W'(1);
          state_d   = ST_SETTLE;
        end
      end

      // Wait until the last strobe has been taken by the bank, so pc_in is current.
      ST_SETTLE: begin
        if (!strobe_busy) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          addr_d  = bus.pc_in;
        end
      end

      ST_HALTED, ST_ERR: begin
        state_d = state_q;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      inc_q     <= 1'b0;
      ref_inc_q <= 1'b0;
      ref_dec_q <= 1'b0;
      depth_q   <= '0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      inc_q     <= inc_d;
      ref_inc_q <= ref_inc_d;
      ref_dec_q <= ref_dec_d;
      depth_q   <= depth_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc_inc      = inc_q;
  assign bus.pc_ref_inc  = ref_inc_q;
  assign bus.pc_ref_dec  = ref_dec_q;
  assign depth           = depth_q;
  assign halted          = halted_q;
  assign err             = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer with a PC-bank model and a delayed-ack imem model.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [DEPTH_W-1:0] depth;
  logic               halted;
  logic               err;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .depth  (depth),
    .halted (halted),
    .err    (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [PC_W-1:0]    bank_init [DEPTH];
  logic [PC_W-1:0]    bank_pc   [DEPTH];
  logic [DEPTH_W-1:0] bank_ref;
  logic [IW-1:0]      imem [1 << PC_W];
  int                 ack_delay = 0;
  int                 wait_cnt;

  logic [PC_W-1:0] exp_addr   [$];
  int              exp_strobe [$];
  logic            prev_req;
  logic [PC_W-1:0] prev_addr;

  // PC bank model: reset loads the preset contexts, strobes then move it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_pc[i] <= bank_init[i];
      bank_ref <= '0;
    end else begin
      if (bus.pc_inc)     bank_pc[bank_ref] <= bank_pc[bank_ref] + 1'b1;
      if (bus.pc_ref_inc) bank_ref <= bank_ref + 1'b1;
      if (bus.pc_ref_dec) bank_ref <= bank_ref - 1'b1;
    end
  end

  assign bus.pc_in = bank_pc[bank_ref];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          wait_cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) wait_cnt <= wait_cnt + 1;
    else                                 wait_cnt <= 0;
  end

  assign bus.imem_ack  = bus.imem_req && (wait_cnt == ack_delay);
  assign bus.imem_data = imem[bus.imem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic popStrobe(input int code);
    if (exp_strobe.size() == 0) checkOutput("unexpected_strobe", 32'(code), 0);
    else                        checkOutput("strobe_kind", 32'(code), 32'(exp_strobe.pop_front()));
  endtask

  // Monitor: fetches and strobes are matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.imem_req && bus.imem_ack) begin
        if (exp_addr.size() == 0) checkOutput("unexpected_fetch", 32'(bus.imem_addr), 32'hFFFF);
        else                      checkOutput("fetch_addr", 32'(bus.imem_addr), 32'(exp_addr.pop_front()));
      end
      if (bus.imem_req && prev_req)
        checkOutput("addr_stable", 32'(bus.imem_addr), 32'(prev_addr));
      if ((32'(bus.pc_inc) + 32'(bus.pc_ref_inc) + 32'(bus.pc_ref_dec)) > 1)
        checkOutput("strobe_onehot", 32'(bus.pc_inc) + 32'(bus.pc_ref_inc) + 32'(bus.pc_ref_dec), 1);
      if (bus.pc_inc)     popStrobe(1);
      if (bus.pc_ref_inc) popStrobe(2);
      if (bus.pc_ref_dec) popStrobe(3);
      prev_req  <= bus.imem_req;
      prev_addr <= bus.imem_addr;
    end else begin
      prev_req <= 1'b0;
    end
  end

  task automatic resetAll();
    rst_n = 1'b0;
    start = 1'b0;
    bus.instr_ready = 1'b1;
    exp_addr.delete();
    exp_strobe.delete();
    for (int i = 0; i < (1 << PC_W); i++) imem[i] = '0;
    for (int i = 0; i < DEPTH; i++) bank_init[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitTerminal(input int limit);
    int n = 0;
    while (!(halted || err) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("terminal_reached", 32'(halted | err), 1);
  endtask

  task automatic checkQueuesEmpty(input string tag);
    checkOutput({tag, "_addr_left"}, 32'(exp_addr.size()), 0);
    checkOutput({tag, "_strobe_left"}, 32'(exp_strobe.size()), 0);
  endtask

  initial begin
    int n;
    bus.instr_ready = 1'b1;

    // Reset state
    resetAll();
    checkOutput("rst_req", 32'(bus.imem_req), 0);
    checkOutput("rst_valid", 32'(bus.instr_valid), 0);
    checkOutput("rst_instr", 32'(bus.instr), 0);
    checkOutput("rst_strobes", 32'({bus.pc_inc, bus.pc_ref_inc, bus.pc_ref_dec}), 0);
    checkOutput("rst_depth", 32'(depth), 0);
    checkOutput("rst_flags", 32'({halted, err}), 0);

    // Plain run
    resetAll();
    ack_delay = 0;
    imem[0] = 16'h1000; imem[1] = 16'h1001; imem[2] = 16'hF000;
    exp_addr = '{9'd0, 9'd1, 9'd2};
    exp_strobe = '{1, 1};
    applyStimulus();
    waitTerminal(100);
    repeat (3) @(negedge clk);
    checkOutput("plain_halted", 32'(halted), 1);
    checkOutput("plain_err", 32'(err), 0);
    checkOutput("plain_depth", 32'(depth), 0);
    checkQueuesEmpty("plain");

    // Call / return
    resetAll();
    bank_init[1] = 9'h040;
    imem[0] = 16'hC000; imem[9'h040] = 16'hD000; imem[1] = 16'hF000;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    exp_addr = '{9'h000, 9'h040, 9'h001};
    exp_strobe = '{1, 2, 3};
    applyStimulus();
    n = 0;
    while (depth != 1 && n < 100) begin @(negedge clk); n++; end
    checkOutput("call_depth1", 32'(depth), 1);
    waitTerminal(100);
    repeat (3) @(negedge clk);
    checkOutput("call_depth0", 32'(depth), 0);
    checkOutput("call_halted", 32'(halted), 1);
    checkQueuesEmpty("call");

    // Overflow: eight nested calls
    resetAll();
    for (int k = 0; k < DEPTH; k++) begin
      bank_init[k] = PC_W'(16 * k);
      imem[16 * k] = 16'hC000;
      exp_addr.push_back(PC_W'(16 * k));
      exp_strobe.push_back(1);
      if (k < DEPTH - 1) exp_strobe.push_back(2);
    end
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    applyStimulus();
    waitTerminal(300);
    repeat (3) @(negedge clk);
    checkOutput("ovf_err", 32'(err), 1);
    checkOutput("ovf_depth", 32'(depth), 7);
    checkOutput("ovf_halted", 32'(halted), 0);
    checkQueuesEmpty("ovf");

    // Underflow: return at depth 0
    resetAll();
    imem[0] = 16'hD000;
    exp_addr = '{9'd0};
    applyStimulus();
    waitTerminal(100);
    repeat (4) @(negedge clk);
    checkOutput("unf_err", 32'(err), 1);
    checkOutput("unf_depth", 32'(depth), 0);
    applyStimulus();
    repeat (4) @(negedge clk);
    checkOutput("unf_frozen_req", 32'(bus.imem_req), 0);
    checkOutput("unf_frozen_valid", 32'(bus.instr_valid), 0);
    checkQueuesEmpty("unf");

    // Backpressure with slow memory
    resetAll();
    ack_delay = 3;
    bus.instr_ready = 1'b0;
    imem[0] = 16'h1234; imem[1] = 16'hF000;
    exp_addr = '{9'd0, 9'd1};
    exp_strobe = '{1};
    applyStimulus();
    n = 0;
    while (!bus.instr_valid && n < 100) begin @(negedge clk); n++; end
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_valid", 32'(bus.instr_valid), 1);
      checkOutput("bp_instr", 32'(bus.instr), 32'h1234);
      @(negedge clk);
    end
    bus.instr_ready = 1'b1;
    waitTerminal(100);
    repeat (3) @(negedge clk);
    checkOutput("bp_halted", 32'(halted), 1);
    checkQueuesEmpty("bp");

    // Asynchronous reset in the middle of a fetch
    resetAll();
    ack_delay = 30;
    bank_init[1] = 9'h040;
    imem[0] = 16'hC000; imem[9'h040] = 16'h1000;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    ack_delay = 0;
    exp_addr = '{9'd0};
    exp_strobe = '{1, 2};
    applyStimulus();
    n = 0;
    while (!(depth == 1 && bus.imem_req) && n < 100) begin
      @(negedge clk);
      if (depth == 1) ack_delay = 30;
      n++;
    end
    checkOutput("ar_pre_req", 32'(bus.imem_req), 1);
    checkOutput("ar_pre_depth", 32'(depth), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_req_drop", 32'(bus.imem_req), 0);
    checkOutput("ar_valid_drop", 32'(bus.instr_valid), 0);
    checkOutput("ar_depth", 32'(depth), 0);
    checkOutput("ar_err", 32'(err), 0);
    checkQueuesEmpty("ar");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
